prt_decoder_seq: RTL and testbench

Sequential 2-to-4 decoder that converts the 2-bit priority code produced by the priority encoder back into a timed one-hot strobe. It accepts one code per valid/ready transaction and drives the matching one-hot line for a programmable number of cycles. It then enforces a programmable idle gap before accepting the next code. It sits downstream of the priority encoder, for example driving grant or enable lines from an encoded request index. A saturating counter records how many codes have been accepted.

---
 rtl/prt_pkg.sv | 14 +
 rtl/prt_dec_timer.sv | 25 ++
 rtl/prt_decoder_seq.sv | 99 +++++++++
 tb/tb_prt_decoder_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/prt_pkg.sv
// Shared types and constants for the priority encoder / decoder pair.
package prt_pkg;

    localparam int          PRT_CODE_W  = 2;
    localparam int          PRT_LINES   = 4;
    localparam logic [7:0]  PRT_CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } prt_dec_state_t;

endpackage

// File: rtl/prt_dec_timer.sv
// Loadable 8-bit down-counter that parks at zero instead of wrapping.
module prt_dec_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != 8'd0) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign zero = (r_count == 8'd0);

endmodule

// File: rtl/prt_decoder_seq.sv
// Sequential 2-to-4 decoder: each accepted code becomes a timed one-hot strobe
// followed by an idle gap; a saturating counter tallies accepted codes.
module prt_decoder_seq
    import prt_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [PRT_CODE_W-1:0] in_code,
    output logic                  in_ready,
    output logic [PRT_LINES-1:0]  out_onehot,
    output logic                  out_active,
    output logic                  busy,
    output logic [7:0]            code_cnt
);

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_LEN - 1);
    localparam bit         HAS_GAP    = (GAP_LEN > 0);

    prt_dec_state_t        r_state;
    prt_dec_state_t        w_next_state;
    logic [PRT_CODE_W-1:0] r_code_q;
    logic [7:0]            r_code_cnt;
    logic                  w_accept;
    logic                  w_load;
    logic [7:0]            w_load_val;
    logic                  w_zero;

    prt_dec_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_val   = PULSE_LOAD;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_load       = 1'b1;
                    w_load_val   = PULSE_LOAD;
                    w_next_state = DRIVE;
                end
            end
            DRIVE: begin
                if (w_zero) begin
                    if (HAS_GAP) begin
                        w_load       = 1'b1;
                        w_load_val   = GAP_LOAD;
                        w_next_state = GAP;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            GAP: begin
                if (w_zero) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset blanks the strobe asynchronously.
    always_comb begin
        in_ready   = (r_state == IDLE);
        out_active = (r_state == DRIVE);
        busy       = (r_state == DRIVE) || (r_state == GAP);
        out_onehot = out_active ? (PRT_LINES'(1) << r_code_q) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code_q   <= '0;
            r_code_cnt <= 8'd0;
        end else if (w_accept) begin
            r_code_q <= in_code;
            if (r_code_cnt != PRT_CNT_MAX) r_code_cnt <= r_code_cnt + 8'd1;
        end
    end

    assign code_cnt = r_code_cnt;

endmodule

// File: tb/tb_prt_decoder_seq.sv
// Bench for prt_decoder_seq: default instance (4/1) and a fast instance (1/0),
// checked every cycle against a timestamp-based model plus directed literals.
module tb_prt_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
    logic [1:0] in_code_a = 2'd0, in_code_b = 2'd0;
    logic       in_ready_a, in_ready_b;
    logic [3:0] out_onehot_a, out_onehot_b;
    logic       out_active_a, out_active_b;
    logic       busy_a, busy_b;
    logic [7:0] code_cnt_a, code_cnt_b;

    int checks = 0;
    int failures = 0;
    int seen [16];

    always #5 clk = ~clk;

    prt_decoder_seq u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_code(in_code_a),
        .in_ready(in_ready_a), .out_onehot(out_onehot_a), .out_active(out_active_a),
        .busy(busy_a), .code_cnt(code_cnt_a)
    );

    prt_decoder_seq #(.PULSE_LEN(1), .GAP_LEN(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_code(in_code_b),
        .in_ready(in_ready_b), .out_onehot(out_onehot_b), .out_active(out_active_b),
        .busy(busy_b), .code_cnt(code_cnt_b)
    );

    // Model: remember the edge index of the last accept; every output follows
    // from how many edges have passed since then.
    int       m_e    [2] = '{0, 0};
    int       m_ka   [2] = '{0, 0};
    logic     m_has  [2] = '{1'b0, 1'b0};
    logic [1:0] m_code [2] = '{2'd0, 2'd0};
    int       m_cnt  [2] = '{0, 0};

    function automatic int plen(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int glen(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic logic exp_busy(input int i);
        return m_has[i] && ((m_e[i] - m_ka[i]) < plen(i) + glen(i));
    endfunction

    function automatic logic exp_active(input int i);
        return m_has[i] && ((m_e[i] - m_ka[i]) < plen(i));
    endfunction

    function automatic logic [3:0] exp_onehot(input int i);
        return exp_active(i) ? (4'b0001 << m_code[i]) : 4'b0000;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_e[i]   <= 0;
                m_ka[i]  <= 0;
                m_has[i] <= 1'b0;
                m_cnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_e[i] <= m_e[i] + 1;
                if (((i == 0) ? in_valid_a : in_valid_b) && !exp_busy(i)) begin
                    m_ka[i]   <= m_e[i] + 1;
                    m_has[i]  <= 1'b1;
                    m_code[i] <= (i == 0) ? in_code_a : in_code_b;
                    m_cnt[i]  <= (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic compare_all();
        check("model_onehot_a", 32'(out_onehot_a), 32'(exp_onehot(0)));
        check("model_active_a", 32'(out_active_a), 32'(exp_active(0)));
        check("model_busy_a",   32'(busy_a),       32'(exp_busy(0)));
        check("model_ready_a",  32'(in_ready_a),   32'(!exp_busy(0)));
        check("model_cnt_a",    32'(code_cnt_a),   32'(m_cnt[0]));
        check("model_onehot_b", 32'(out_onehot_b), 32'(exp_onehot(1)));
        check("model_active_b", 32'(out_active_b), 32'(exp_active(1)));
        check("model_busy_b",   32'(busy_b),       32'(exp_busy(1)));
        check("model_ready_b",  32'(in_ready_b),   32'(!exp_busy(1)));
        check("model_cnt_b",    32'(code_cnt_b),   32'(m_cnt[1]));
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst_n) begin
            compare_all();
            seen[out_onehot_a]++;
        end
    endtask

    task automatic do_reset();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present a code on instance a, wait (bounded) for ready, return just after the accepting edge.
    task automatic send_a(input logic [1:0] c, input bit hold);
        int n;
        n = 0;
        in_valid_a = 1'b1;
        in_code_a  = c;
        while (!in_ready_a && n < 500) begin
            tick();
            n++;
        end
        if (!in_ready_a) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: in_ready stayed %0b, expected 1 within 500 cycles", in_ready_a);
        end
        tick();
        if (!hold) in_valid_a = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) seen[i] = 0;

        // Reset state
        do_reset();
        check("rst_onehot_a", 32'(out_onehot_a), 32'h0);
        check("rst_ready_a",  32'(in_ready_a),   32'h1);
        check("rst_busy_a",   32'(busy_a),       32'h0);
        check("rst_active_a", 32'(out_active_a), 32'h0);
        check("rst_cnt_a",    32'(code_cnt_a),   32'h0);
        check("rst_onehot_b", 32'(out_onehot_b), 32'h0);
        check("rst_ready_b",  32'(in_ready_b),   32'h1);
        check("rst_cnt_b",    32'(code_cnt_b),   32'h0);

        // Single code 2: four cycles of 0100, one gap cycle, then ready
        repeat (9) tick();
        send_a(2'd2, 1'b0);
        for (int j = 0; j < 4; j++) begin
            check("single_strobe", 32'(out_onehot_a), 32'h4);
            tick();
        end
        check("single_gap_onehot", 32'(out_onehot_a), 32'h0);
        check("single_gap_busy",   32'(busy_a),       32'h1);
        check("single_gap_ready",  32'(in_ready_a),   32'h0);
        tick();
        check("single_ready_back", 32'(in_ready_a),   32'h1);
        check("single_cnt",        32'(code_cnt_a),   32'h1);

        // Back-to-back 0,1,3 with valid held high
        do_reset();
        tick();
        for (int i = 0; i < 16; i++) seen[i] = 0;
        send_a(2'd0, 1'b1);
        send_a(2'd1, 1'b1);
        send_a(2'd3, 1'b0);
        repeat (8) tick();
        check("b2b_cycles_0001", 32'(seen[1]), 32'd4);
        check("b2b_cycles_0010", 32'(seen[2]), 32'd4);
        check("b2b_cycles_1000", 32'(seen[8]), 32'd4);
        check("b2b_cycles_0100", 32'(seen[4]), 32'd0);
        check("b2b_cnt",         32'(code_cnt_a), 32'd3);

        // Valid pulse with code 3 during DRIVE of code 1 is ignored
        do_reset();
        tick();
        send_a(2'd1, 1'b0);
        in_valid_a = 1'b1;
        in_code_a  = 2'd3;
        tick();
        in_valid_a = 1'b0;
        check("ignore_strobe_d1", 32'(out_onehot_a), 32'h2);
        repeat (2) tick();
        check("ignore_strobe_d3", 32'(out_onehot_a), 32'h2);
        repeat (4) tick();
        check("ignore_cnt", 32'(code_cnt_a), 32'd1);

        // Asynchronous reset in the second DRIVE cycle
        do_reset();
        tick();
        send_a(2'd2, 1'b0);
        tick();
        check("arst_pre_onehot", 32'(out_onehot_a), 32'h4);
        #1 rst_n = 1'b0;
        #1;
        check("arst_onehot", 32'(out_onehot_a), 32'h0);
        check("arst_cnt",    32'(code_cnt_a),   32'h0);
        check("arst_busy",   32'(busy_a),       32'h0);
        #1 rst_n = 1'b1;
        send_a(2'd0, 1'b0);
        check("arst_next_onehot", 32'(out_onehot_a), 32'h1);
        repeat (6) tick();

        // Random traffic on a; fast instance b saturates its counter
        for (int n = 0; n < 620; n++) begin
            in_valid_a = 1'($urandom_range(0, 1));
            in_code_a  = 2'($urandom_range(0, 3));
            in_valid_b = 1'b1;
            in_code_b  = 2'($urandom_range(0, 3));
            tick();
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        repeat (8) tick();
        check("sat_cnt_b", 32'(code_cnt_b), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
